sram_row_reader: RTL and testbench
==================================

Name: sram_row_reader

Overview:
- Upstream read-streamer for the matrix datapath.
- Fetches a block of consecutive rows (DATA_LEN*N bits each) from one on-chip SRAM port and presents them as a valid/ready row stream to the matrix engine.
- Hides the SRAM read latency with credit-based issue into a small internal FIFO, so the engine never sees raw SRAM timing.

Parameters:
- DATA_LEN, 32: bits per matrix element.
- N, 8: elements per row; row width = DATA_LEN*N.
- ADDRESS_SIZE, 4: SRAM word-address width.
- READ_LATENCY, 1: cycles from address driven to i_read_data valid (1..3).
- FIFO_DEPTH, 4: row buffer entries; must be >= READ_LATENCY+2 (checked at elaboration).

Ports:
- i_clk, input, 1: single clock; all logic on the rising edge.
- i_rstn, input, 1: asynchronous active-low reset.
- i_start, input, 1: one-cycle request to begin a transfer; sampled only in IDLE.
- i_base_addr, input, ADDRESS_SIZE: first row address.
- i_num_rows, input, ADDRESS_SIZE+1: rows to fetch (0..2^ADDRESS_SIZE).
- o_address, output, ADDRESS_SIZE: SRAM address.
- o_wr_en, output, 1: SRAM write enable; constant 0.
- i_read_data, input, DATA_LEN*N: SRAM read data.
- o_row_data, output, DATA_LEN*N: head-of-FIFO row.
- o_row_valid, output, 1: o_row_data is valid.
- i_row_ready, input, 1: consumer accepts a row when o_row_valid && i_row_ready.
- o_busy, output, 1: high in any state other than IDLE.
- o_done, output, 1: one-cycle pulse after the last row is accepted.
- o_state, output, 2: IDLE=0, READ=1, DRAIN=2, DONE=3.

Behaviour:
- Reset (async assert, synchronous release); all outputs 0 during reset:
  - state=IDLE; o_address, o_row_data, o_row_valid, o_busy and o_done all 0.
  - FIFO, in-flight pipeline, and issue/accept counters cleared.
- Reset mid-transfer: in-flight reads are discarded and no row is emitted afterwards.
- IDLE:
  - i_start=1 latches base and count.
  - If i_num_rows=0: go to DONE (o_done pulses the next cycle, no SRAM access).
  - Otherwise go to READ.
- READ:
  - Each cycle where issued<count and (in_flight + fifo_count) < FIFO_DEPTH:
    - drive o_address = base+issued, modulo 2^ADDRESS_SIZE (wrap, no error);
    - increment issued;
    - push a valid token into a READ_LATENCY-deep shift pipeline.
  - o_address holds its last value when not issuing.
  - When issued==count, go to DRAIN.
- Data capture:
  - A token exiting the pipeline in cycle c writes i_read_data into the FIFO at the end of cycle c.
  - The row is visible on o_row_data/o_row_valid from cycle c+1.
  - Credit rule guarantees the FIFO never overflows; no data is dropped.
- Output:
  - First-word-fall-through; o_row_data is stable while o_row_valid && !i_row_ready.
  - Pop on handshake; a simultaneous push and pop leaves the count unchanged.
- DRAIN: when accepted==count, go to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Latency and throughput:
  - i_start sampled at edge s → first address in cycle s+1 → first o_row_valid in cycle s+2+READ_LATENCY (s+3 for READ_LATENCY=1).
  - With i_row_ready held high, throughput is 1 row/cycle.
- i_start outside IDLE is ignored; base and count do not change mid-transfer.
- Row order on the output equals address order exactly.

Test Plan:
- Base=0, num=8, READ_LATENCY=1, ready=1, SRAM word k=k·0x11 pattern:
  - rows 0..7 appear on consecutive cycles, first at start+3;
  - o_done one cycle after the 8th handshake;
  - o_busy falls with the return to IDLE.
- Base=14, num=4:
  - addresses issued 14,15,0,1 (wrap);
  - data order matches.
- Backpressure, num=8, ready low for cycles 4–9:
  - at most FIFO_DEPTH rows outstanding + buffered;
  - o_row_data frozen while stalled;
  - no row lost or duplicated.
- num=0:
  - DONE pulse 1 cycle after start;
  - no o_address change;
  - o_row_valid never asserted.
- Reset asserted while 3 rows are buffered:
  - all outputs 0 immediately;
  - after release, a new start with base=2, num=2 yields exactly rows 2,3.
- i_start re-pulsed mid-READ: ignored, row count unchanged (8). Then repeat the first scenario with READ_LATENCY=3, FIFO_DEPTH=5: first row at start+5, still 1 row/cycle.

Source files
------------

// File: rtl/sram_row_reader.sv
// sram_row_reader: streams a block of consecutive SRAM rows out as a valid/ready row stream.
// Reads are issued against a credit count so that every read in flight already owns a
// FIFO slot. The consumer therefore sees first-word-fall-through rows, never raw SRAM timing.
//
// Handshake: a row transfers on a rising edge where o_row_valid && i_row_ready. Once
// o_row_valid is high it stays high, and o_row_data stays stable, until that transfer.
module sram_row_reader #(
  parameter int DATA_LEN     = 32,
  parameter int N            = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_start,
  input  logic [ADDRESS_SIZE-1:0]   i_base_addr,
  input  logic [ADDRESS_SIZE:0]     i_num_rows,
  output logic [ADDRESS_SIZE-1:0]   o_address,
  output logic                      o_wr_en,
  input  logic [DATA_LEN*N-1:0]     i_read_data,
  output logic [DATA_LEN*N-1:0]     o_row_data,
  output logic                      o_row_valid,
  input  logic                      i_row_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [1:0]                o_state
);

  localparam int RW = DATA_LEN * N;
  localparam int CW = ADDRESS_SIZE + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
    $error("sram_row_reader: FIFO_DEPTH must be at least READ_LATENCY+2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
    $error("sram_row_reader: READ_LATENCY must be 1..3");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDRESS_SIZE-1:0] base_q;
  logic [CW-1:0]          count_q, issued_q, accepted_q;
  // Stage 0 marks the cycle the address is on the SRAM port; the tail marks the cycle the
  // matching read data is valid on i_read_data, READ_LATENCY cycles later.
  logic [READ_LATENCY:0]  pipe_q;
  logic [RW-1:0]          mem [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [FW-1:0]          fifo_cnt;
  logic [OW-1:0]          in_flight, occupancy;
  logic                   push, pop, issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push        = pipe_q[READ_LATENCY];
  assign o_row_valid = (fifo_cnt != '0);
  assign pop         = o_row_valid && i_row_ready;
  assign o_row_data  = o_row_valid ? mem[rd_ptr] : '0;
  assign o_wr_en     = 1'b0;
  assign o_state     = state;
  assign o_busy      = (state != S_IDLE);
  assign o_done      = (state == S_DONE);

  // Credit check: slots already claimed by reads in flight plus buffered rows, less the row leaving now.
  always_comb begin
    in_flight = '0;
    for (int k = 0; k <= READ_LATENCY; k++) begin
      in_flight = in_flight + OW'(pipe_q[k]);
    end
    occupancy = in_flight + OW'(fifo_cnt) - OW'(pop);
    issue     = (state == S_READ) && (issued_q != count_q) && (occupancy < OW'(FIFO_DEPTH));
  end

  // Next-state logic; DRAIN looks at the current handshake so o_done follows the last accept by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = (i_num_rows == '0) ? S_DONE : S_READ;
      S_READ:  if (issued_q == count_q) state_nxt = S_DRAIN;
      S_DRAIN: if (accepted_q + CW'(pop) == count_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Transfer bookkeeping: latch request, issue addresses, count accepted rows, track in-flight reads.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      o_address  <= '0;
      pipe_q     <= '0;
    end else begin
      if (state == S_IDLE && i_start) begin
        base_q     <= i_base_addr;
        count_q    <= i_num_rows;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) begin
          o_address <= base_q + issued_q[ADDRESS_SIZE-1:0];
          issued_q  <= issued_q + CW'(1);
        end
        if (pop) accepted_q <= accepted_q + CW'(1);
      end
      pipe_q <= {pipe_q[READ_LATENCY-1:0], issue};
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + FW'(push) - FW'(pop);
    end
  end

  // Row storage; contents are only observable through a valid head, so it needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_read_data;
  end

endmodule

// File: tb/tb_sram_row_reader.sv
// Directed bench for sram_row_reader: one instance with READ_LATENCY=1/FIFO_DEPTH=4 and one
// with READ_LATENCY=3/FIFO_DEPTH=5, each fed by a bench-side SRAM model of matching latency.
module tb_sram_row_reader;
  localparam int DL = 32;
  localparam int NE = 8;
  localparam int AW = 4;
  localparam int RW = DL * NE;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, start, start3, ready;
  logic [AW-1:0] base;
  logic [AW:0]   num;

  logic [AW-1:0] addr, addr3;
  logic          wr_en, wr_en3, valid, valid3, busy, busy3, done, done3;
  logic [RW-1:0] rd, rd3, row_data, row_data3, p0, p1, p2;
  logic [1:0]    state, state3;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  sram_row_reader #(.DATA_LEN(DL), .N(NE), .ADDRESS_SIZE(AW), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_base_addr(base), .i_num_rows(num),
    .o_address(addr), .o_wr_en(wr_en), .i_read_data(rd), .o_row_data(row_data),
    .o_row_valid(valid), .i_row_ready(ready), .o_busy(busy), .o_done(done), .o_state(state));

  sram_row_reader #(.DATA_LEN(DL), .N(NE), .ADDRESS_SIZE(AW), .READ_LATENCY(3), .FIFO_DEPTH(5)) dut3 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start3), .i_base_addr(base), .i_num_rows(num),
    .o_address(addr3), .o_wr_en(wr_en3), .i_read_data(rd3), .o_row_data(row_data3),
    .o_row_valid(valid3), .i_row_ready(ready), .o_busy(busy3), .o_done(done3), .o_state(state3));

  // Row pattern: element j of word k = k*0x11 + (j<<20), so every row is distinct and nonzero.
  function automatic logic [RW-1:0] row_of(input logic [AW-1:0] k);
    logic [RW-1:0] r;
    for (int j = 0; j < NE; j++) r[j*DL +: DL] = 32'(k) * 32'h11 + (32'(j) << 20);
    return r;
  endfunction

  // SRAM models: latency 1 and latency 3.
  always @(posedge clk) rd <= row_of(addr);
  always @(posedge clk) begin
    p0 <= row_of(addr3);
    p1 <= p0;
    p2 <= p1;
  end
  assign rd3 = p2;

  // ---------------- monitor / scoreboard capture ----------------
  logic [RW-1:0] got_q[$];
  logic [RW-1:0] got3_q[$];
  int            got_cyc[$];
  int            got3_cyc[$];
  int            valid_cnt = 0;
  int            stall_seen = 0;
  int            stall_bad = 0;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_data;

  always @(negedge clk) begin
    if (rstn) begin
      if (valid) valid_cnt <= valid_cnt + 1;
      if (valid && ready) begin
        got_q.push_back(row_data);
        got_cyc.push_back(cyc_n);
      end
      if (valid3 && ready) begin
        got3_q.push_back(row_data3);
        got3_cyc.push_back(cyc_n);
      end
      if (prev_stall) begin
        stall_seen <= stall_seen + 1;
        if (row_data !== prev_data) stall_bad <= stall_bad + 1;
      end
    end
    prev_stall <= rstn && valid && !ready;
    prev_data  <= row_data;
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; s is the cycle that begins at the sampling edge.
  task automatic start_xfer(input bit sel3, input logic [AW-1:0] b, input logic [AW:0] n, output int s);
    base = b;
    num  = n;
    if (sel3) start3 = 1'b1;
    else      start  = 1'b1;
    tick();
    start  = 1'b0;
    start3 = 1'b0;
    s = cyc_n;
  endtask

  task automatic wait_done(input bit sel3, output int dc);
    for (int i = 0; i < 200; i++) begin
      if ((sel3 ? done3 : done) === 1'b1) break;
      tick();
    end
    dc = cyc_n;
    chk_i("done_seen", int'(sel3 ? done3 : done), 1);
  endtask

  // Compare accepted rows from idx0 onward with rows b, b+1, ...; first_cyc<0 skips timing.
  task automatic check_rows(input bit sel3, input int idx0, input logic [AW-1:0] b, input int n,
                            input int first_cyc);
    int sz;
    sz = sel3 ? got3_q.size() : got_q.size();
    chk_i("row_count", sz - idx0, n);
    for (int k = 0; k < n; k++) begin
      if (idx0 + k < sz) begin
        chk_r("row_data_order", sel3 ? got3_q[idx0+k] : got_q[idx0+k], row_of(b + AW'(k)));
        if (first_cyc >= 0)
          chk_i("row_cycle", sel3 ? got3_cyc[idx0+k] : got_cyc[idx0+k], first_cyc + k);
      end
    end
  endtask

  task automatic check_reset_outs();
    chk_i("rst_state", int'(state), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_valid", int'(valid), 0);
    chk_i("rst_addr", int'(addr), 0);
    chk_i("rst_wr_en", int'(wr_en), 0);
    chk_r("rst_row_data", row_data, '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s, dc, idx0, vc0, st0, sb0;
    rstn = 1'b0; start = 1'b0; start3 = 1'b0; ready = 1'b1; base = '0; num = '0;
    tick();
    tick();
    check_reset_outs();
    chk_i("rst_state3", int'(state3), 0);
    chk_i("rst_busy3", int'(busy3), 0);
    chk_i("rst_done3", int'(done3), 0);
    chk_i("rst_valid3", int'(valid3), 0);
    chk_i("rst_wr_en3", int'(wr_en3), 0);
    rstn = 1'b1;
    tick();

    // 1) base 0, 8 rows, ready high: rows on consecutive cycles from s+3, done at s+11.
    idx0 = got_q.size();
    start_xfer(1'b0, 4'd0, 5'd8, s);
    chk_i("s1_state_read", int'(state), 1);
    chk_i("s1_busy", int'(busy), 1);
    tick();
    chk_i("s1_addr0", int'(addr), 0);
    chk_i("s1_valid_s1", int'(valid), 0);
    tick();
    chk_i("s1_addr1", int'(addr), 1);
    chk_i("s1_valid_s2", int'(valid), 0);
    tick();
    chk_i("s1_valid_s3", int'(valid), 1);
    chk_r("s1_first_row", row_data, row_of(4'd0));
    wait_done(1'b0, dc);
    chk_i("s1_done_cycle", dc, s + 11);
    chk_i("s1_busy_in_done", int'(busy), 1);
    check_rows(1'b0, idx0, 4'd0, 8, s + 3);
    tick();
    chk_i("s1_done_pulse_len", int'(done), 0);
    chk_i("s1_idle", int'(state), 0);
    chk_i("s1_busy_low", int'(busy), 0);

    // 2) base 14, 4 rows: addresses wrap 14,15,0,1.
    idx0 = got_q.size();
    start_xfer(1'b0, 4'd14, 5'd4, s);
    tick();
    chk_i("s2_addr14", int'(addr), 14);
    tick();
    chk_i("s2_addr15", int'(addr), 15);
    tick();
    chk_i("s2_addr0", int'(addr), 0);
    chk_r("s2_first_row", row_data, row_of(4'd14));
    tick();
    chk_i("s2_addr1", int'(addr), 1);
    wait_done(1'b0, dc);
    check_rows(1'b0, idx0, 4'd14, 4, s + 3);
    tick();

    // 3) backpressure: ready low for cycles s+4..s+9.
    idx0 = got_q.size();
    st0 = stall_seen;
    sb0 = stall_bad;
    start_xfer(1'b0, 4'd0, 5'd8, s);
    for (int i = 0; i < 4; i++) tick();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_i("s3_addr_credit_stop", int'(addr), 4);
    chk_i("s3_valid_stalled", int'(valid), 1);
    chk_r("s3_head_stalled", row_data, row_of(4'd1));
    tick();
    ready = 1'b1;
    wait_done(1'b0, dc);
    check_rows(1'b0, idx0, 4'd0, 8, -1);
    chk_i("s3_stall_cycles", stall_seen - st0, 6);
    chk_i("s3_frozen_data", stall_bad - sb0, 0);
    tick();

    // 4) num 0: done the cycle after start, no address change, no valid.
    vc0 = valid_cnt;
    start_xfer(1'b0, 4'd9, 5'd0, s);
    chk_i("s4_done", int'(done), 1);
    chk_i("s4_state_done", int'(state), 3);
    chk_i("s4_addr_hold", int'(addr), 7);
    tick();
    chk_i("s4_done_low", int'(done), 0);
    chk_i("s4_idle", int'(state), 0);
    tick();
    chk_i("s4_addr_hold2", int'(addr), 7);
    chk_i("s4_no_valid", valid_cnt - vc0, 0);

    // 5) reset with 3 rows buffered, then base 2, 2 rows.
    ready = 1'b0;
    start_xfer(1'b0, 4'd0, 5'd8, s);
    for (int i = 0; i < 5; i++) tick();
    chk_i("s5_buffered_valid", int'(valid), 1);
    chk_r("s5_buffered_head", row_data, row_of(4'd0));
    rstn = 1'b0;
    #1;
    check_reset_outs();
    tick();
    tick();
    check_reset_outs();
    rstn = 1'b1;
    ready = 1'b1;
    vc0 = valid_cnt;
    for (int i = 0; i < 4; i++) tick();
    chk_i("s5_no_stale_rows", valid_cnt - vc0, 0);
    idx0 = got_q.size();
    start_xfer(1'b0, 4'd2, 5'd2, s);
    wait_done(1'b0, dc);
    check_rows(1'b0, idx0, 4'd2, 2, s + 3);
    tick();
    tick();
    chk_i("s5_no_extra", got_q.size() - idx0, 2);

    // 6) start re-pulsed mid-READ with other base/num: ignored.
    idx0 = got_q.size();
    start_xfer(1'b0, 4'd0, 5'd8, s);
    tick();
    tick();
    base = 4'd5;
    num = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, dc);
    check_rows(1'b0, idx0, 4'd0, 8, s + 3);
    tick();

    // 7) READ_LATENCY=3, FIFO_DEPTH=5: first row at s+5, 1 row/cycle, done at s+13.
    idx0 = got3_q.size();
    start_xfer(1'b1, 4'd0, 5'd8, s);
    chk_i("s7_busy3", int'(busy3), 1);
    tick();
    chk_i("s7_addr3_0", int'(addr3), 0);
    for (int i = 0; i < 3; i++) tick();
    chk_i("s7_valid3_s4", int'(valid3), 0);
    tick();
    chk_i("s7_valid3_s5", int'(valid3), 1);
    chk_r("s7_first_row3", row_data3, row_of(4'd0));
    wait_done(1'b1, dc);
    chk_i("s7_done3_cycle", dc, s + 13);
    check_rows(1'b1, idx0, 4'd0, 8, s + 5);
    tick();
    chk_i("s7_idle3", int'(state3), 0);
    chk_i("s7_busy3_low", int'(busy3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
